// File: rtl/cache_flush_seq.sv
// Walks every tag line: reads it, writes dirty lines back when asked, then invalidates it. Costs 3 cycles per invalid line and 5 per valid line.
// The write-back stalls on i_mem_ready and i_mem_resp, and new requests are refused until the walk ends.
module cache_flush_seq #(
  parameter int abus    = 64,
  parameter int waybits = 2,
  parameter int ibits   = 6,
  parameter int lnbits  = 5,
  parameter int flbits  = 4
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic                         i_flush_valid,
  input  logic                         i_flush_wb,
  output logic                         o_flush_ready,
  output logic                         o_flush_end,
  output logic [ibits+waybits:0]       o_wb_cnt,
  output logic                         o_tag_direct_access,
  output logic                         o_tag_re,
  output logic                         o_tag_invalidate,
  output logic [abus-1:0]              o_tag_addr,
  input  logic [abus-1:0]              i_tag_raddr,
  input  logic [8*(2**lnbits)-1:0]     i_tag_rdata,
  input  logic [flbits-1:0]            i_tag_rflags,
  input  logic                         i_tag_hit,
  output logic                         o_mem_valid,
  input  logic                         i_mem_ready,
  output logic [abus-1:0]              o_mem_addr,
  output logic [8*(2**lnbits)-1:0]     o_mem_wdata,
  input  logic                         i_mem_resp
);

  localparam int cbits = ibits + waybits;

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_RESP, WB_REQ, WB_WAIT, INV_REQ, INV_WR, NEXT, DONE
  } state_t;

  state_t                 state;
  logic [cbits-1:0]       cnt;
  logic                   wb_q;
  logic [abus-1:lnbits]   raddr_q;

  logic [cbits-1:0]       cnt_inc;
  logic [lnbits-1:0]      way_pad;
  logic [lnbits-1:0]      way_pad_inc;
  logic [abus-1:0]        rd_addr_next;

  assign cnt_inc      = cnt + 1'b1;
  assign way_pad      = lnbits'(cnt[waybits-1:0]);
  assign way_pad_inc  = lnbits'(cnt_inc[waybits-1:0]);
  assign rd_addr_next = abus'({cnt_inc[cbits-1:waybits], way_pad_inc});

  // Only VALID and DIRTY steer the walk; hit and the line offset carry no information here.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_tag_hit, i_tag_raddr[lnbits-1:0], i_tag_rflags[flbits-1:2]};

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state               <= IDLE;
      cnt                 <= '0;
      wb_q                <= 1'b0;
      raddr_q             <= '0;
      o_wb_cnt            <= '0;
      o_flush_ready       <= 1'b1;
      o_flush_end         <= 1'b0;
      o_tag_direct_access <= 1'b0;
      o_tag_re            <= 1'b0;
      o_tag_invalidate    <= 1'b0;
      o_tag_addr          <= '0;
      o_mem_valid         <= 1'b0;
      o_mem_addr          <= '0;
      o_mem_wdata         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_flush_valid) begin
            wb_q                <= i_flush_wb;
            cnt                 <= '0;
            o_wb_cnt            <= '0;
            o_flush_ready       <= 1'b0;
            o_tag_direct_access <= 1'b1;
            o_tag_re            <= 1'b1;
            o_tag_addr          <= '0;
            state               <= RD_REQ;
          end
        end
        RD_REQ: begin
          o_tag_direct_access <= 1'b0;
          o_tag_re            <= 1'b0;
          o_tag_addr          <= '0;
          state               <= RD_RESP;
        end
        RD_RESP: begin
          raddr_q <= i_tag_raddr[abus-1:lnbits];
          if (!i_tag_rflags[0]) begin
            state <= NEXT;
          end else if (i_tag_rflags[1] && wb_q) begin
            o_mem_valid <= 1'b1;
            o_mem_addr  <= {i_tag_raddr[abus-1:lnbits], {lnbits{1'b0}}};
            o_mem_wdata <= i_tag_rdata;
            state       <= WB_REQ;
          end else begin
            o_tag_direct_access <= 1'b1;
            o_tag_invalidate    <= 1'b1;
            o_tag_addr          <= {i_tag_raddr[abus-1:lnbits], way_pad};
            state               <= INV_REQ;
          end
        end
        WB_REQ: begin
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            state       <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          if (i_mem_resp) begin
            o_wb_cnt            <= o_wb_cnt + 1'b1;
            o_tag_direct_access <= 1'b1;
            o_tag_invalidate    <= 1'b1;
            o_tag_addr          <= {raddr_q, way_pad};
            state               <= INV_REQ;
          end
        end
        INV_REQ: begin
          // Address stays up for one more cycle while the tag memory writes the cleared flags.
          o_tag_invalidate <= 1'b0;
          state            <= INV_WR;
        end
        INV_WR: begin
          o_tag_direct_access <= 1'b0;
          o_tag_addr          <= '0;
          state               <= NEXT;
        end
        NEXT: begin
          if (&cnt) begin
            o_flush_end <= 1'b1;
            state       <= DONE;
          end else begin
            cnt                 <= cnt_inc;
            o_tag_direct_access <= 1'b1;
            o_tag_re            <= 1'b1;
            o_tag_addr          <= rd_addr_next;
            state               <= RD_REQ;
          end
        end
        DONE: begin
          o_flush_end   <= 1'b0;
          o_flush_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_flush_seq.md
CACHE_FLUSH_SEQ -- requirements
Module: cache_flush_seq

Interface
REQ-001 The block SHALL have parameter abus, default 64, system bus address width.
REQ-002 The block SHALL have parameter waybits, default 2, log2 of the number of ways.
REQ-003 The block SHALL have parameter ibits, default 6, line index width.
REQ-004 The block SHALL have parameter lnbits, default 5, log2 of bytes per line.
REQ-005 The block SHALL have parameter flbits, default 4, number of tag flags; bit 0 is VALID, bit 1 is DIRTY.
REQ-006 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows:
- i_clk  in  1  CPU clock
- i_nrst  in  1  synchronous reset, active LOW
REQ-007 The block SHALL have the flush request and status ports:
- i_flush_valid  in  1  flush request
- i_flush_wb  in  1  1 = write back dirty lines before invalidating
- o_flush_ready  out  1  idle and able to accept a request
- o_flush_end  out  1  one-cycle completion pulse
- o_wb_cnt  out  ibits+waybits+1  count of lines written back
REQ-008 The block SHALL have the tag-memory initiator ports:
- o_tag_direct_access  out  1  direct access request
- o_tag_re  out  1  read request
- o_tag_invalidate  out  1  invalidate request
- o_tag_addr  out  abus  access address
- i_tag_raddr  in  abus  line address read back
- i_tag_rdata  in  8*2^lnbits  line data read back
- i_tag_rflags  in  flbits  line flags read back
- i_tag_hit  in  1  hit indication
REQ-009 The block SHALL have the write-back port:
- o_mem_valid  out  1  write request valid
- i_mem_ready  in  1  write request accepted
- o_mem_addr  out  abus  write address
- o_mem_wdata  out  8*2^lnbits  write data
- i_mem_resp  in  1  write completion acknowledge

Function
REQ-010 The block SHALL use the states IDLE, RD_REQ, RD_RESP, WB_REQ, WB_WAIT, INV_REQ, INV_WR, NEXT and DONE, and a line counter cnt of ibits+waybits bits.
- cnt[waybits-1:0] selects the way.
- cnt[ibits+waybits-1:waybits] selects the index.
REQ-011 In IDLE, o_flush_ready SHALL be 1; in every other state it SHALL be 0.
REQ-012 In IDLE, if i_flush_valid=1, the block SHALL do the following on that edge:
- latch i_flush_wb
- clear cnt and o_wb_cnt
- go to RD_REQ
REQ-013 i_flush_valid SHALL be ignored in every state other than IDLE.
REQ-014 In RD_REQ, the block SHALL drive the following for one cycle, then go to RD_RESP:
- o_tag_direct_access=1
- o_tag_re=1
- o_tag_addr = index<<lnbits with the way in bits [waybits-1:0]
REQ-015 In RD_RESP, the block SHALL register i_tag_raddr, i_tag_rdata and i_tag_rflags, then take the first matching transition:
- VALID=0 -> NEXT
- VALID=1, DIRTY=1 and latched wb=1 -> WB_REQ
- otherwise -> INV_REQ
REQ-016 In WB_REQ, the block SHALL drive o_mem_valid=1, o_mem_addr = latched raddr with bits [lnbits-1:0] zeroed, and o_mem_wdata = latched rdata.
- Address and data SHALL stay stable until i_mem_ready=1.
- On the edge with i_mem_ready=1, the block SHALL go to WB_WAIT.
REQ-017 In WB_WAIT, o_mem_valid SHALL be 0; on i_mem_resp=1 the block SHALL increment o_wb_cnt and go to INV_REQ.
REQ-018 In INV_REQ, the block SHALL drive the following, then go to INV_WR:
- o_tag_direct_access=1
- o_tag_invalidate=1
- o_tag_addr = latched raddr[abus-1:lnbits] concatenated with lnbits low bits holding the way in [waybits-1:0]
REQ-019 In INV_WR, the block SHALL drive o_tag_direct_access=1, o_tag_invalidate=0 and the same o_tag_addr as INV_REQ, then go to NEXT.
- The tag memory writes the cleared flags in this cycle.
REQ-020 In NEXT, if cnt is all ones the block SHALL go to DONE; otherwise it SHALL increment cnt and go to RD_REQ.
REQ-021 In DONE, o_flush_end SHALL be 1 for exactly one cycle, then the block SHALL go to IDLE.
REQ-022 Outside the states that drive them, all tag and memory request outputs SHALL be 0.
REQ-023 Per-line cycle cost SHALL be:
- invalid line: 3 cycles
- valid clean line, or any valid line with wb=0: 5 cycles
- dirty line with wb=1: 5 cycles plus the memory handshake time
REQ-024 o_wb_cnt SHALL hold its value after DONE until the next accepted flush.

Reset
REQ-025 When i_nrst=0 at a clock edge, the block SHALL set state=IDLE, cnt=0, o_wb_cnt=0 and latched wb=0.
REQ-026 While in reset and on the first cycle after it, outputs SHALL be:
- o_flush_ready=1
- o_flush_end=0
- o_mem_valid=0
- all o_tag_* outputs = 0
REQ-027 Reset asserted mid-flush SHALL abort the flush with no o_flush_end pulse; a pending memory request is dropped.

Verification
REQ-028 Defaults, all lines invalid, flush accepted at edge E -> o_flush_end is high in the cycle beginning at edge E+768, and o_wb_cnt=0.
REQ-029 One line valid+dirty at index 3, way 2, tag address 0x8000_0060, wb=1, i_mem_ready held 0 for 5 cycles -> o_mem_addr=0x8000_0060 with wdata stable throughout the stall.
- The subsequent INV_REQ drives o_tag_addr=0x8000_0062.
- At the end, o_wb_cnt=1.
REQ-030 Same cache contents with wb=0 -> o_mem_valid never asserts, the line is invalidated, and o_wb_cnt=0.
REQ-031 i_flush_valid pulsed during RD_RESP of line 5 -> ignored; exactly one o_flush_end pulse occurs.
REQ-032 i_nrst=0 during WB_REQ -> the next cycle has o_mem_valid=0, o_flush_ready=1, o_flush_end=0; a new flush then restarts at cnt=0.
